// File: rtl/arcade_video_timing.sv
// Raster timing generator: pixel enable, H/V counters, blanks, syncs and frame pulse.
// All outputs registered and updated together on the pixel-enable edge; no backpressure.
module arcade_video_timing #(
   parameter int CLK_DIV      = 4,
   parameter int H_TOTAL      = 384,
   parameter int H_ACTIVE     = 256,
   parameter int H_SYNC_START = 288,
   parameter int H_SYNC_W     = 32,
   parameter int V_TOTAL      = 264,
   parameter int V_ACTIVE     = 240,
   parameter int V_SYNC_START = 244,
   parameter int V_SYNC_W     = 3
) (
   input  logic       clk_video,
   input  logic       reset,
   input  logic [3:0] h_adj,
   input  logic [3:0] v_adj,
   output logic       ce_pix,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       HBlank,
   output logic       VBlank,
   output logic       HSync,
   output logic       VSync,
   output logic       frame_start
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

   // 12-bit signed sync arithmetic leaves headroom for start+adj near 1023
   localparam logic signed [11:0] HSS = 12'(H_SYNC_START);
   localparam logic signed [11:0] HLO = 12'(H_ACTIVE);
   localparam logic signed [11:0] HHI = 12'(H_TOTAL - H_SYNC_W);
   localparam logic signed [11:0] HW  = 12'(H_SYNC_W);
   localparam logic signed [11:0] VSS = 12'(V_SYNC_START);
   localparam logic signed [11:0] VLO = 12'(V_ACTIVE);
   localparam logic signed [11:0] VHI = 12'(V_TOTAL - V_SYNC_W);
   localparam logic signed [11:0] VW  = 12'(V_SYNC_W);

   function automatic logic signed [11:0] clamp(input logic signed [11:0] x,
                                                input logic signed [11:0] lo,
                                                input logic signed [11:0] hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   logic [DW-1:0] div;
   logic [3:0]    hadj_r, vadj_r;
   logic          tick, h_wrap, adj_latch;
   logic [9:0]    hcnt_n, vcnt_n;
   logic [3:0]    hadj_n, vadj_n;
   logic signed [11:0] hs_raw, vs_raw, hs_start, vs_start, hpos, vpos;
   logic          hsync_n, vsync_n;

   assign tick = (div == DIV_LAST);

   always_comb begin
      h_wrap    = (hcnt == H_LAST);
      hcnt_n    = h_wrap ? 10'd0 : hcnt + 10'd1;
      vcnt_n    = vcnt;
      if (h_wrap) begin
         vcnt_n = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end
      // adjust is captured as VBlank rises and applies from that line onward
      adj_latch = h_wrap && (vcnt_n == V_ACT);
      hadj_n    = adj_latch ? h_adj : hadj_r;
      vadj_n    = adj_latch ? v_adj : vadj_r;

      hs_raw    = HSS + {{8{hadj_n[3]}}, hadj_n};
      vs_raw    = VSS + {{8{vadj_n[3]}}, vadj_n};
      hs_start  = clamp(hs_raw, HLO, HHI);
      vs_start  = clamp(vs_raw, VLO, VHI);
      hpos      = $signed({2'b00, hcnt_n});
      vpos      = $signed({2'b00, vcnt_n});
      hsync_n   = (hpos >= hs_start) && (hpos < hs_start + HW);
      vsync_n   = (vpos >= vs_start) && (vpos < vs_start + VW);
   end

   always_ff @(posedge clk_video) begin
      if (reset) begin
         div         <= '0;
         ce_pix      <= 1'b0;
         hcnt        <= 10'd0;
         vcnt        <= 10'd0;
         HBlank      <= 1'b0;
         VBlank      <= 1'b0;
         HSync       <= 1'b0;
         VSync       <= 1'b0;
         frame_start <= 1'b0;
         hadj_r      <= 4'd0;
         vadj_r      <= 4'd0;
      end else begin
         div    <= tick ? '0 : div + DW'(1);
         ce_pix <= tick;
         if (tick) begin
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            HBlank      <= (hcnt_n >= H_ACT);
            VBlank      <= (vcnt_n >= V_ACT);
            HSync       <= hsync_n;
            VSync       <= vsync_n;
            frame_start <= (hcnt_n == 10'd0) && (vcnt_n == 10'd0);
            hadj_r      <= hadj_n;
            vadj_r      <= vadj_n;
         end
      end
   end

endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing on a reduced raster: per-cycle reference model plus
// table-driven sync-window measurements and hand-written reset sequences.
module tb_arcade_video_timing;

   localparam int CD = 4, HT = 40, HA = 24, HSS = 28, HSW = 4;
   localparam int VT = 30, VA = 20, VSS = 24, VSW = 2;
   localparam int FRAME = CD * HT * VT;

   logic       clk_video = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] h_adj = 4'd0;
   logic [3:0] v_adj = 4'd0;
   logic       ce_pix, HBlank, VBlank, HSync, VSync, frame_start;
   logic [9:0] hcnt, vcnt;

   always #5 clk_video = ~clk_video;

   arcade_video_timing #(
      .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_W(VSW)
   ) dut (
      .clk_video(clk_video), .reset(reset), .h_adj(h_adj), .v_adj(v_adj),
      .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt), .HBlank(HBlank), .VBlank(VBlank),
      .HSync(HSync), .VSync(VSync), .frame_start(frame_start)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;          // clocks since reset release
   int m_hadj = 0, m_vadj = 0;

   typedef struct {
      logic [3:0] ha;
      logic [3:0] va;
      int hs_first, hs_last, vs_first, vs_last;
   } vec_t;
   vec_t tbl[5];

   function automatic int sx4(input logic [3:0] a);
      return a[3] ? int'(a) - 16 : int'(a);
   endfunction

   function automatic int clampi(input int x, input int lo, input int hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock, then advance the reference raster and compare every output
   task automatic step();
      int p, h, v, hs, vs;
      logic [25:0] expv, actv;
      @(posedge clk_video);
      #1;
      if (reset) begin
         cyc = 0; m_hadj = 0; m_vadj = 0;
      end else begin
         cyc++;
         if (cyc % CD == 0) begin
            p = cyc / CD;
            if ((p % HT) == 0 && ((p / HT) % VT) == VA) begin
               m_hadj = sx4(h_adj);
               m_vadj = sx4(v_adj);
            end
         end
      end
      p  = cyc / CD;
      h  = p % HT;
      v  = (p / HT) % VT;
      hs = clampi(HSS + m_hadj, HA, HT - HSW);
      vs = clampi(VSS + m_vadj, VA, VT - VSW);
      expv = {(cyc > 0 && cyc % CD == 0), 10'(h), 10'(v), (h >= HA), (v >= VA),
              (h >= hs && h < hs + HSW), (v >= vs && v < vs + VSW),
              (p > 0 && h == 0 && v == 0)};
      actv = {ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync, frame_start};
      check("raster", int'(actv), int'(expv));
   endtask

   task automatic wait_pos(input int h, input int v, input string nm);
      int n;
      for (n = 0; n < FRAME + 200; n++) begin
         step();
         if (ce_pix && hcnt == 10'(h) && vcnt == 10'(v)) break;
      end
      if (n >= FRAME + 200) check({"timeout_", nm}, 0, 1);
   endtask

   task automatic wait_fs();
      int  n;
      logic prev;
      prev = frame_start;
      for (n = 0; n < FRAME + 200; n++) begin
         step();
         if (frame_start && !prev) break;
         prev = frame_start;
      end
      if (n >= FRAME + 200) check("timeout_fs", 0, 1);
   endtask

   task automatic measure(output int hmin, output int hmax, output int vmin, output int vmax,
                          output int hedges, output int vedges);
      logic ph, pv;
      hmin = 1024; hmax = -1; vmin = 1024; vmax = -1; hedges = 0; vedges = 0;
      ph = HSync; pv = VSync;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (HSync) begin
            if (int'(hcnt) < hmin) hmin = int'(hcnt);
            if (int'(hcnt) > hmax) hmax = int'(hcnt);
         end
         if (VSync) begin
            if (int'(vcnt) < vmin) vmin = int'(vcnt);
            if (int'(vcnt) > vmax) vmax = int'(vcnt);
         end
         if (HSync && !ph) hedges++;
         if (VSync && !pv) vedges++;
         ph = HSync; pv = VSync;
      end
   endtask

   initial begin
      int hmin, hmax, vmin, vmax, he, ve, prev_hs;

      tbl[0] = '{4'h0, 4'h0, 28, 31, 24, 25};
      tbl[1] = '{4'h8, 4'h7, 24, 27, 28, 29};
      tbl[2] = '{4'h7, 4'h8, 35, 38, 20, 21};
      tbl[3] = '{4'hC, 4'h3, 24, 27, 27, 28};
      tbl[4] = '{4'hF, 4'hF, 27, 30, 23, 24};

      // reset, release, pixel enable cadence
      repeat (3) step();
      check("rst_outputs", int'({ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync, frame_start}), 0);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check("ce_cadence", int'(ce_pix), (k % 4 == 0) ? 1 : 0);
         check("hcnt_early", int'(hcnt), k / 4);
      end
      check("blank_early", int'({HBlank, VBlank}), 0);

      wait_fs();
      prev_hs = HSS;
      for (int e = 0; e < 5; e++) begin
         wait_pos(0, 10, "line10");
         h_adj = tbl[e].ha;
         v_adj = tbl[e].va;
         // current frame keeps the previously latched position
         wait_pos(prev_hs, 10, "cur_hs");
         check("cur_frame_hsync", int'(HSync), 1);
         wait_fs();
         measure(hmin, hmax, vmin, vmax, he, ve);
         check("hs_first", hmin, tbl[e].hs_first);
         check("hs_last",  hmax, tbl[e].hs_last);
         check("vs_first", vmin, tbl[e].vs_first);
         check("vs_last",  vmax, tbl[e].vs_last);
         check("hs_edges", he, VT);
         check("vs_edges", ve, 1);
         prev_hs = tbl[e].hs_first;
      end

      // reset while both syncs are active; latched adjust must clear
      wait_pos(30, 24, "in_sync");
      check("pre_rst_syncs", int'({HSync, VSync}), 3);
      h_adj = 4'h8;
      v_adj = 4'h7;
      reset = 1'b1;
      step();
      check("mid_rst_outputs", int'({ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync, frame_start}), 0);
      reset = 1'b0;
      wait_pos(HSS - 1, 0, "nom_pre");
      check("nom_hs_pre", int'(HSync), 0);
      wait_pos(HSS, 0, "nom_start");
      check("nom_hs_start", int'(HSync), 1);

      // randomized adjust changes and occasional resets against the model
      for (int s = 0; s < 40; s++) begin
         h_adj = 4'($urandom);
         v_adj = 4'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            reset = 1'b0;
         end
         repeat ($urandom_range(50, 400)) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
